// File: rtl/dn_ib_ram_loader.sv
// Refreshes the DN IB-RAM once per decoding iteration: fetches page data from the
// DN memory latches and writes DN_LOAD_CYCLE consecutive pages into the IB-RAM.
module dn_ib_ram_loader #(
  parameter int ROM_RD_BW      = 2,
  parameter int PAGE_ADDR_BW   = 6,
  parameter int DN_LOAD_CYCLE  = 64,
  parameter int ITER_ADDR_BW   = 6,
  parameter int MAX_ITER       = 50,
  parameter int ITER_ROM_GROUP = 25,
  parameter int ROM_LATENCY    = 2
) (
  input  logic                    write_clk,
  input  logic                    rstn,
  input  logic                    iter_update_req,
  input  logic                    iter_clear,
  input  logic [ROM_RD_BW-1:0]    latch_dinA,
  input  logic [ROM_RD_BW-1:0]    latch_dinB,
  output logic                    rom_fetch_en,
  output logic                    ram_we,
  output logic [PAGE_ADDR_BW-1:0] ram_waddr,
  output logic [ROM_RD_BW-1:0]    ram_doutA,
  output logic [ROM_RD_BW-1:0]    ram_doutB,
  output logic [ITER_ADDR_BW-1:0] iter_cnt,
  output logic                    iter_switch,
  output logic                    busy,
  output logic                    done,
  output logic                    req_overrun
);

  localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]        LAT_LAST  = LAT_W'(ROM_LATENCY - 1);
  localparam logic [PAGE_ADDR_BW-1:0] ADDR_LAST = PAGE_ADDR_BW'(DN_LOAD_CYCLE - 1);
  localparam logic [ITER_ADDR_BW-1:0] ITER_LAST = ITER_ADDR_BW'(MAX_ITER - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [ROM_RD_BW-1:0] dout_a_p0;
  logic [ROM_RD_BW-1:0] dout_b_p0;

  // Stage p0: latch data registered once; the write slot lines up with it
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      dout_a_p0 <= '0;
      dout_b_p0 <= '0;
    end else begin
      dout_a_p0 <= latch_dinA;
      dout_b_p0 <= latch_dinB;
    end
  end

  assign ram_doutA   = dout_a_p0;
  assign ram_doutB   = dout_b_p0;
  assign iter_switch = (iter_cnt >= ITER_ADDR_BW'(ITER_ROM_GROUP));

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      rom_fetch_en <= 1'b0;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      iter_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      req_overrun  <= 1'b0;
    end else begin
      done        <= 1'b0;
      req_overrun <= iter_update_req && (state != IDLE);
      case (state)
        IDLE: begin
          if (iter_clear) begin
            iter_cnt <= '0;
          end else if (iter_update_req) begin
            state        <= FETCH;
            rom_fetch_en <= 1'b1;
            busy         <= 1'b1;
            lat_cnt      <= '0;
          end
        end
        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            state     <= WRITE;
            ram_we    <= 1'b1;
            ram_waddr <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        WRITE: begin
          if (ram_waddr == ADDR_LAST) begin
            state        <= DONE;
            ram_we       <= 1'b0;
            rom_fetch_en <= 1'b0;
            done         <= 1'b1;
            iter_cnt     <= (iter_cnt == ITER_LAST) ? '0 : iter_cnt + ITER_ADDR_BW'(1);
          end else begin
            ram_waddr <= ram_waddr + PAGE_ADDR_BW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // A clear while busy abandons the refresh and restarts the iteration sequence
      if (iter_clear && (state != IDLE)) begin
        state        <= IDLE;
        ram_we       <= 1'b0;
        rom_fetch_en <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        iter_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dn_ib_ram_loader.sv
// Scoreboard bench for dn_ib_ram_loader: expected page writes are queued as latch
// data is driven and retired as the IB-RAM write port produces them.
module tb_dn_ib_ram_loader;

  localparam int N_PAGES = 64;

  logic       write_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       iter_update_req = 1'b0;
  logic       iter_clear = 1'b0;
  logic [1:0] latch_dinA = '0;
  logic [1:0] latch_dinB = '0;
  logic       rom_fetch_en, ram_we, iter_switch, busy, done, req_overrun;
  logic [5:0] ram_waddr, iter_cnt;
  logic [1:0] ram_doutA, ram_doutB;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  int exp_iter = 0;
  int seed     = 0;
  int sb[$];

  dn_ib_ram_loader dut (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .iter_update_req (iter_update_req),
    .iter_clear      (iter_clear),
    .latch_dinA      (latch_dinA),
    .latch_dinB      (latch_dinB),
    .rom_fetch_en    (rom_fetch_en),
    .ram_we          (ram_we),
    .ram_waddr       (ram_waddr),
    .ram_doutA       (ram_doutA),
    .ram_doutB       (ram_doutB),
    .iter_cnt        (iter_cnt),
    .iter_switch     (iter_switch),
    .busy            (busy),
    .done            (done),
    .req_overrun     (req_overrun)
  );

  always #5 write_clk = ~write_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  // Retire one expected write per ram_we cycle
  always @(negedge write_clk) begin
    if (rstn) begin
      if (done) done_cnt++;
      if (ram_we) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          chk("wr_data", int'(ram_waddr) * 16 + int'(ram_doutA) * 4 + int'(ram_doutB),
              sb.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch_en"}, int'(rom_fetch_en), 0);
    chk({tag, "_we"}, int'(ram_we), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_overrun"}, int'(req_overrun), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_waddr"}, int'(ram_waddr), 0);
    chk({tag, "_doutA"}, int'(ram_doutA), 0);
    chk({tag, "_doutB"}, int'(ram_doutB), 0);
    chk({tag, "_iter"}, int'(iter_cnt), 0);
    chk({tag, "_switch"}, int'(iter_switch), 0);
  endtask

  // One refresh; ovr_k/clr_k/rst_k >= 0 inject a request/clear/reset alongside page k
  task automatic run_refresh(input int ovr_k, input int clr_k, input int rst_k);
    int base_done, base_wr, a, b;
    bit aborted;
    aborted   = 1'b0;
    base_done = done_cnt;
    base_wr   = wr_cnt;
    seed++;
    iter_update_req = 1'b1;
    tick();
    iter_update_req = 1'b0;
    chk("fetch_en_first", int'(rom_fetch_en), 1);
    chk("busy_fetch", int'(busy), 1);
    chk("we_fetch1", int'(ram_we), 0);
    tick();
    chk("we_fetch2", int'(ram_we), 0);
    for (int k = 0; k < N_PAGES; k++) begin
      a = (k + seed) % 4;
      b = int'($urandom_range(0, 3));
      latch_dinA = 2'(a);
      latch_dinB = 2'(b);
      sb.push_back(k * 16 + a * 4 + b);
      if (k == ovr_k) iter_update_req = 1'b1;
      if (k == clr_k) iter_clear = 1'b1;
      if (k == rst_k) rstn = 1'b0;
      tick();
      iter_update_req = 1'b0;
      iter_clear = 1'b0;
      rstn = 1'b1;
      if (k == rst_k) begin
        chk_reset_outputs("rst_abort");
        aborted = 1'b1;
      end else if (k == clr_k) begin
        chk("clr_we", int'(ram_we), 0);
        chk("clr_fetch_en", int'(rom_fetch_en), 0);
        chk("clr_iter", int'(iter_cnt), 0);
        chk("clr_busy", int'(busy), 0);
        aborted = 1'b1;
      end else begin
        chk("overrun", int'(req_overrun), (k == ovr_k) ? 1 : 0);
      end
      if (aborted) break;
    end
    if (aborted) begin
      sb.delete();
      exp_iter = 0;
      repeat (4) tick();
      chk("abort_no_done", done_cnt, base_done);
      chk("abort_idle_busy", int'(busy), 0);
    end else begin
      chk("last_we", int'(ram_we), 1);
      chk("last_waddr", int'(ram_waddr), N_PAGES - 1);
      chk("last_fetch_en", int'(rom_fetch_en), 1);
      tick();
      exp_iter = (exp_iter == 49) ? 0 : exp_iter + 1;
      chk("done_pulse", int'(done), 1);
      chk("done_we", int'(ram_we), 0);
      chk("done_fetch_en", int'(rom_fetch_en), 0);
      chk("done_busy", int'(busy), 1);
      chk("done_iter", int'(iter_cnt), exp_iter);
      chk("done_waddr_hold", int'(ram_waddr), N_PAGES - 1);
      tick();
      chk("post_done", int'(done), 0);
      chk("post_busy", int'(busy), 0);
      chk("write_count", wr_cnt - base_wr, N_PAGES);
      chk("done_count", done_cnt - base_done, 1);
      chk("sb_drained", sb.size(), 0);
      chk("iter_switch", int'(iter_switch), (exp_iter >= 25) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    repeat (7) tick();

    run_refresh(-1, -1, -1);
    run_refresh(28, -1, -1);

    // Clear with simultaneous request while idle: request is discarded quietly
    iter_clear = 1'b1;
    iter_update_req = 1'b1;
    tick();
    iter_clear = 1'b0;
    iter_update_req = 1'b0;
    exp_iter = 0;
    chk("idle_clr_iter", int'(iter_cnt), 0);
    chk("idle_clr_busy", int'(busy), 0);
    chk("idle_clr_fetch_en", int'(rom_fetch_en), 0);
    chk("idle_clr_overrun", int'(req_overrun), 0);
    tick();
    chk("idle_clr_still_idle", int'(busy), 0);

    repeat (7) run_refresh(-1, -1, -1);
    chk("iter_before_abort", int'(iter_cnt), 7);
    run_refresh(-1, 18, -1);
    run_refresh(-1, 1, -1);
    run_refresh(-1, -1, 38);
    run_refresh(-1, -1, -1);

    iter_clear = 1'b1;
    tick();
    iter_clear = 1'b0;
    exp_iter = 0;
    chk("clr_to_zero", int'(iter_cnt), 0);
    for (int r = 0; r < 50; r++) run_refresh(-1, -1, -1);
    chk("wrap_iter", int'(iter_cnt), 0);
    chk("wrap_switch", int'(iter_switch), 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
